// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit seven-segment display.
// Double-buffered BCD digits; new values are swapped in only at frame start.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    output logic [3:0]              bcd_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    frame_done_o,
    output logic                    load_ack_o
);

    localparam int unsigned MaxCnt = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned DataW  = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   idx_next;
    logic [CntW-1:0]   cnt_q;
    logic [DataW-1:0]  active_q;
    logic [DataW-1:0]  pending_q;
    logic              pending_valid_q;
    logic [DataW-1:0]  start_active;
    logic              start_ack;

    function automatic logic [3:0] digit_of(input logic [DataW-1:0] vec,
                                            input logic [IdxW-1:0] i);
        logic [DataW-1:0] sh;
        sh = vec >> {i, 2'b00};
        return sh[3:0];
    endfunction

    assign idx_next = idx_q + IdxW'(1);

    // Buffer contents that take effect if this edge is a frame start; a
    // coincident load bypasses the pending buffer.
    always_comb begin
        start_active = active_q;
        start_ack    = 1'b0;
        if (load_i) begin
            start_active = data_i;
            start_ack    = 1'b1;
        end else if (pending_valid_q) begin
            start_active = pending_q;
            start_ack    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            cnt_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            bcd_o           <= 4'd0;
            dig_en_o        <= '0;
            frame_done_o    <= 1'b0;
            load_ack_o      <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            load_ack_o   <= 1'b0;
            if (load_i) begin
                pending_q       <= data_i;
                pending_valid_q <= 1'b1;
            end
            if (!en_i) begin
                state_q  <= StIdle;
                idx_q    <= '0;
                cnt_q    <= '0;
                bcd_o    <= 4'd0;
                dig_en_o <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q  <= StBlank;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        dig_en_o <= '0;
                        active_q <= start_active;
                        bcd_o    <= digit_of(start_active, '0);
                        if (start_ack) begin
                            load_ack_o      <= 1'b1;
                            pending_valid_q <= 1'b0;
                        end
                    end
                    StBlank: begin
                        bcd_o <= digit_of(active_q, idx_q);
                        if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                            state_q  <= StDrive;
                            cnt_q    <= '0;
                            dig_en_o <= NUM_DIGITS'(1) << idx_q;
                        end else begin
                            cnt_q    <= cnt_q + CntW'(1);
                            dig_en_o <= '0;
                        end
                    end
                    StDrive: begin
                        if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
                            state_q  <= StBlank;
                            cnt_q    <= '0;
                            dig_en_o <= '0;
                            if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
                                idx_q        <= '0;
                                frame_done_o <= 1'b1;
                                active_q     <= start_active;
                                bcd_o        <= digit_of(start_active, '0);
                                if (start_ack) begin
                                    load_ack_o      <= 1'b1;
                                    pending_valid_q <= 1'b0;
                                end
                            end else begin
                                idx_q <= idx_next;
                                bcd_o <= digit_of(active_q, idx_next);
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        dig_en_o <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus random
// traffic against a frame-position model of the scan.
module tb_seven_seg_scan_ctrl;

    localparam int unsigned N     = 4;
    localparam int unsigned R     = 4;
    localparam int unsigned B     = 2;
    localparam int unsigned SLOT  = B + R;
    localparam int unsigned FRAME = N * SLOT;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [4*N-1:0] data;
    logic [3:0]    bcd;
    logic [N-1:0]  dig_en;
    logic          frame_done;
    logic          load_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: position within the frame, counted from the first BLANK cycle.
    bit            m_run;
    int            m_t;
    logic [4*N-1:0] m_active;
    logic [4*N-1:0] m_pend;
    bit            m_pv;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .load_i      (load),
        .data_i      (data),
        .bcd_o       (bcd),
        .dig_en_o    (dig_en),
        .frame_done_o(frame_done),
        .load_ack_o  (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_t      = 0;
        m_active = '0;
        m_pend   = '0;
        m_pv     = 1'b0;
    endtask

    task automatic tick();
        bit          fs;
        bit          fd;
        bit          e_ack;
        int          d;
        logic [N-1:0] e_dig;
        logic [4*N-1:0] sh;
        @(posedge clk);
        fs = 1'b0;
        fd = 1'b0;
        if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            fs    = 1'b1;
        end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
                fs = 1'b1;
                fd = 1'b1;
            end
        end
        e_ack = 1'b0;
        if (fs && load) begin
            m_active = data;
            m_pv     = 1'b0;
            e_ack    = 1'b1;
        end else if (fs && m_pv) begin
            m_active = m_pend;
            m_pv     = 1'b0;
            e_ack    = 1'b1;
        end else if (load) begin
            m_pend = data;
            m_pv   = 1'b1;
        end
        d     = m_t / SLOT;
        e_dig = (m_run && (m_t % SLOT) >= B) ? N'(1) << d : '0;
        sh    = m_active >> (4 * d);
        #1;
        chk("dig_en", 32'(dig_en), 32'(e_dig));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
        if (m_run) chk("bcd", 32'(bcd), 32'(sh[3:0]));
    endtask

    task automatic step(input bit e, input bit l, input logic [4*N-1:0] d);
        en   = e;
        load = l;
        data = d;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, data);
    endtask

    // Advance with en high until the model sits at frame position target.
    task automatic run_until(input int target);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            if (m_run && m_t == target) begin
                reached = 1'b1;
                break;
            end
            step(1'b1, 1'b0, data);
        end
        chk("run_until", 32'(reached), 32'd1);
    endtask

    initial begin
        en    = 1'b0;
        load  = 1'b0;
        data  = '0;
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_load_ack", 32'(load_ack), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Steady scan of 4321.
        step(1'b0, 1'b1, 16'h4321);
        run(2 * FRAME + 1);

        // Tear-free update while digit 2 drives.
        run_until(14);
        step(1'b1, 1'b1, 16'h9876);
        run(2 * FRAME);

        // Double load, last wins.
        run_until(3);
        step(1'b1, 1'b1, 16'h1111);
        step(1'b1, 1'b1, 16'h2222);
        run(2 * FRAME);

        // Load coincident with the wrap edge.
        run_until(FRAME - 1);
        step(1'b1, 1'b1, 16'h5A5A);
        chk("wrap_load_ack", 32'(load_ack), 32'd1);
        chk("wrap_bcd", 32'(bcd), 32'hA);
        run(2 * FRAME);

        // Enable drop during digit 1 drive, with A..F pass-through.
        step(1'b1, 1'b1, 16'hFEDC);
        run(FRAME);
        run_until(9);
        step(1'b0, 1'b0, data);
        chk("drop_dig_en", 32'(dig_en), 32'd0);
        step(1'b0, 1'b0, data);
        step(1'b0, 1'b1, 16'hBA98);
        step(1'b1, 1'b0, data);
        chk("reen_frame_done", 32'(frame_done), 32'd0);
        run(2 * FRAME);

        // Asynchronous reset mid-drive.
        run_until(15);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_dig_en", 32'(dig_en), 32'd0);
        chk("async_bcd", 32'(bcd), 32'd0);
        chk("async_frame_done", 32'(frame_done), 32'd0);
        chk("async_load_ack", 32'(load_ack), 32'd0);
        #3;
        rst_n = 1'b1;
        run(2);
        chk("latency_blank", 32'(dig_en), 32'd0);
        run(1);
        chk("latency_first", 32'(dig_en), 32'd1);
        run(FRAME);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-cathode seven-segment display.
- Holds a double-buffered set of BCD digits and presents one digit at a time on a 4-bit BCD bus, which feeds the team's combinational BCD-to-segment decoder.
- Drives the matching one-hot digit-enable line, with a blanking guard interval between digits to suppress ghosting.
- Frame updates are tear-free: new digit values take effect only at frame boundaries.

Parameters:
- NUM_DIGITS, 4, number of display digits. Legal range is 2..8.
- REFRESH_DIV, 50000, number of clock cycles each digit is actively driven. Must be at least 1.
- BLANK_CYCLES, 16, number of clock cycles all digits are off before each digit is driven. Must be at least 1.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  scan enable. High runs the scan; low blanks the display.
- load_i  input  1  one-cycle strobe that captures data_i into the pending buffer.
- data_i  input  4*NUM_DIGITS  BCD digits. Digit k occupies bits [4k+3:4k]; digit 0 is at the right of the display.
- bcd_o  output  4  BCD value of the currently selected digit, to the decoder input.
- dig_en_o  output  NUM_DIGITS  one-hot digit enable, active high. All zero while blanked.
- frame_done_o  output  1  one-cycle pulse at the end of the last digit's drive window.
- load_ack_o  output  1  one-cycle pulse when the pending buffer is transferred to the active buffer.

Behaviour:
- Reset (asynchronous, rst_n_i low) clears the following:
  - bcd_o = 0, dig_en_o = 0, frame_done_o = 0, load_ack_o = 0.
  - Active buffer and pending buffer = 0; pending_valid = 0.
  - Digit index = 0; cycle counter = 0; state = IDLE.
- All outputs are registered.
- States:
  - IDLE: dig_en_o = 0, index = 0, counter = 0.
  - BLANK: dig_en_o = 0; bcd_o = active[index]; runs for BLANK_CYCLES cycles.
  - DRIVE: dig_en_o = one-hot(index); bcd_o = active[index]; runs for REFRESH_DIV cycles.
- State transitions:
  - IDLE -> BLANK at the first edge where en_i = 1.
  - BLANK -> DRIVE when the counter reaches BLANK_CYCLES-1. The counter then clears.
  - DRIVE -> BLANK when the counter reaches REFRESH_DIV-1. The counter clears and the index advances.
  - Index wrap: when the index is NUM_DIGITS-1, it wraps to 0 and frame_done_o pulses for the first cycle of the new BLANK.
  - en_i = 0 in any state -> IDLE at the next edge, with outputs blanked on that edge. A partially driven frame is abandoned.
- Frame start is defined as entry into BLANK with index 0, either from IDLE or on wrap.
- Pending buffer:
  - load_i = 1 captures data_i into pending and sets pending_valid.
  - A second load before the next frame start overwrites pending (last write wins).
- Transfer at frame start:
  - If pending_valid = 1, pending is copied to active, pending_valid clears, and load_ack_o pulses in the same cycle.
  - If load_i = 1 on the frame-start edge, data_i bypasses the pending buffer: it goes straight to active, load_ack_o pulses, and pending_valid ends at 0.
- bcd_o passes values 10..15 through unchanged; the decoder defines their segment patterns.
- Timing:
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
  - Latency from en_i rising to the first dig_en_o assertion is 1 + BLANK_CYCLES edges.
- Invariants:
  - dig_en_o never has more than one bit set.
  - dig_en_o is never nonzero on two consecutive digits without an intervening blank of at least BLANK_CYCLES cycles.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, giving a 24-cycle frame.
1. Reset mid-DRIVE: assert rst_n_i asynchronously between edges -> dig_en_o, bcd_o and both pulses go to 0 immediately. After release with en_i=1, the first dig_en_o=0001 appears 3 edges later.
2. Steady scan:
   - Stimulus: load data_i=16'h4321, then set en_i=1.
   - Required sequence: bcd_o = 1, 2, 3, 4, with dig_en_o = 0001, 0010, 0100, 1000, each held 4 cycles and preceded by 2 cycles of 0000.
   - frame_done_o pulses every 24 cycles.
3. Tear-free update:
   - Stimulus: with 16'h4321 displayed, pulse load_i with 16'h9876 while digit 2 is driving.
   - Required: digits 2 and 3 still show 3 and 4. The next frame shows 6, 7, 8, 9, and load_ack_o pulses once at that frame start.
4. Double load, last wins: load 16'h1111, then load 16'h2222 before the boundary -> the next frame shows all 2s, with a single load_ack_o pulse.
5. Load on the frame-start edge: load_i=1 coincident with the wrap -> the new value is visible in the same frame's digit 0, load_ack_o pulses, and no second ack occurs at the next frame.
6. Enable drop:
   - Stimulus: en_i=0 during digit 1 DRIVE.
   - Required: dig_en_o=0000 at the next edge. On re-enable, the scan restarts at digit 0 after 2 blank cycles, with no frame_done_o for the abandoned frame.
   - Check: values 4'hA..4'hF pass through to bcd_o unchanged.
